mux_3x1_1bit: RTL and testbench

//  - 3-to-1 single-bit multiplexer for datapath and control-signal selection in the RISC-V core.
//  - Output X is purely combinational, with zero latency from A/B/C/S.
//  - Adds a registered copy X_q for timing-critical consumers.
//  - Adds a flag for the unused select code.

---
 rtl/mux_3x1_1bit_pkg.sv | 17 +
 rtl/mux_3x1_1bit_reg.sv | 29 ++
 rtl/mux_3x1_1bit.sv | 53 +++++
 tb/tb_mux_3x1_1bit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mux_3x1_1bit_pkg.sv
// mux_3x1_1bit_pkg
//   Shared select encodings for the 3:1 single-bit mux plus a small
//   decode helper. Any other mux adopting the same S encoding should
//   import this package instead of redefining the codes.
package mux_3x1_1bit_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Flags the unused select code.
  function automatic logic sel_is_none(input logic [1:0] s);
    return (s == SEL_NONE);
  endfunction

endpackage

// File: rtl/mux_3x1_1bit_reg.sv
// mux_3x1_1bit_reg
//   1-bit register with synchronous active-high reset.
// Ports
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; clears q to 0
//   d      in  next value
//   q      out registered value
module mux_3x1_1bit_reg (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mux_3x1_1bit.sv
// mux_3x1_1bit
//   3-to-1 single-bit mux for datapath/control selection. X is purely
//   combinational (valid with clk idle); X_q is a one-cycle registered
//   copy for timing-critical consumers; sel_invalid flags S = 2'b11.
// Ports
//   clk          in   1  clock, only X_q uses it
//   reset        in   1  synchronous active-high, clears X_q only
//   A, B, C      in   1  data inputs for S = 00 / 01 / 10
//   S            in   2  select
//   X            out  1  combinational mux output (0 for S = 11)
//   X_q          out  1  X registered on clk
//   sel_invalid  out  1  combinational, 1 when S = 11
module mux_3x1_1bit
  import mux_3x1_1bit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic [1:0] S,
  output logic       X,
  output logic       X_q,
  output logic       sel_invalid
);

  logic x_d;

  // A case on S only reads the selected input, so X/Z on an unselected
  // input cannot leak into X. The default arm only fires for X/Z on S in
  // simulation and propagates X rather than silently picking A.
  always_comb begin
    x_d = 1'b0;
    case (S)
      SEL_A:    x_d = A;
      SEL_B:    x_d = B;
      SEL_C:    x_d = C;
      SEL_NONE: x_d = 1'b0;
      default:  x_d = 1'bx;
    endcase
  end

  assign X           = x_d;
  assign sel_invalid = sel_is_none(S);

  mux_3x1_1bit_reg u_x_reg (
    .clk   (clk),
    .reset (reset),
    .d     (x_d),
    .q     (X_q)
  );

endmodule

// File: tb/tb_mux_3x1_1bit.sv
module tb_mux_3x1_1bit;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       A, B, C;
  logic [1:0] S;
  logic       X, X_q, sel_invalid;

  int n_tests;
  int n_fail;

  mux_3x1_1bit dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .B           (B),
    .C           (C),
    .S           (S),
    .X           (X),
    .X_q         (X_q),
    .sel_invalid (sel_invalid)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic a, input logic b, input logic c);
    S = s; A = a; B = b; C = c;
  endtask

  logic [31:0] exp_x;  // truth table indexed by {S,A,B,C}
  logic        ex;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    reset   = 1'b1;
    drive(2'b00, 1'b1, 1'b0, 1'b1);

    // Reset state: one edge with reset high clears X_q.
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_xq", X_q, 1'b0);
    @(negedge clk);
    clk_en = 1'b0;  // clock parked low for the combinational tests
    reset  = 1'b0;

    // 1: S=00 follows A, clock idle.
    drive(2'b00, 1'b1, 1'b0, 1'b1); #10;
    chk("t1_x", X, 1'b1);
    chk("t1_inv", sel_invalid, 1'b0);

    // 2: S=01 follows B, toggling B moves X without a clock.
    drive(2'b01, 1'b1, 1'b0, 1'b1); #1;
    chk("t2_x", X, 1'b0);
    B = 1'b1; #1;
    chk("t2_xtog", X, 1'b1);

    // 3: S=10 follows C, unselected toggles don't move X.
    drive(2'b10, 1'b1, 1'b0, 1'b1); #1;
    chk("t3_x", X, 1'b1);
    A = 1'b0; B = 1'b1; #1;
    chk("t3_xhold", X, 1'b1);
    drive(2'b10, 1'b1, 1'b1, 1'b0); #1;
    chk("t3_xc0", X, 1'b0);

    // 4: S=11 forces 0 and flags invalid; back to 00.
    drive(2'b11, 1'b1, 1'b1, 1'b1); #1;
    chk("t4_x", X, 1'b0);
    chk("t4_inv", sel_invalid, 1'b1);
    S = 2'b00; #1;
    chk("t4_inv0", sel_invalid, 1'b0);
    chk("t4_x1", X, 1'b1);
    chk("t4_xq_idle", X_q, 1'b0);  // no edge yet, still reset value

    // Simultaneous S and data change.
    drive(2'b01, 1'b0, 1'b0, 1'b0); #1;
    chk("simul_x", X, 1'b0);

    // 5: registered path and mid-operation reset.
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("t5_xq", X_q, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_xq_rst", X_q, 1'b0);
    chk("t5_x_rst", X, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_xq_rel", X_q, 1'b1);

    // X_q captures only the value present at the edge.
    @(negedge clk);
    A = 1'b0; #1; A = 1'b1; #1; A = 1'b0;
    @(posedge clk); #1;
    chk("edge_only", X_q, 1'b0);

    // 6: exhaustive sweep. Bit i of exp_x is X for {S,A,B,C} = i:
    //   S=00 -> A (i[2]), S=01 -> B (i[1]), S=10 -> C (i[0]), S=11 -> 0.
    exp_x = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      case (i[4:3])
        2'd0:    exp_x[i] = i[2];
        2'd1:    exp_x[i] = i[1];
        2'd2:    exp_x[i] = i[0];
        default: exp_x[i] = 1'b0;
      endcase
    end
    // Hand-computed check of the table: S=00 ones at 4..7, S=01 at 10,11,14,15,
    // S=10 at 17,19,21,23 -> 0x00AA_CCF0.
    chk("table", (exp_x == 32'h00AA_CCF0), 1'b1);

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      @(negedge clk);
      drive(v[4:3], v[2], v[1], v[0]);
      ex = exp_x[i];
      #1;
      chk($sformatf("sweep_x_%0d", i), X, ex);
      chk($sformatf("sweep_inv_%0d", i), sel_invalid, (v[4:3] == 2'b11));
      @(posedge clk); #1;
      chk($sformatf("sweep_xq_%0d", i), X_q, ex);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
